// File: rtl/command_arbiter.sv
// command_arbiter: two-source byte arbiter with per-source FIFOs,
// atomic round-robin command grants and a starvation abort.
module command_arbiter #(
  parameter int         FIFO_DEPTH              = 16,
  parameter int         TIMEOUT_CYCLES          = 65535,
  parameter logic [7:0] CONTROLLER_STATE_READY  = 8'h00,
  parameter logic [7:0] CONTROLLER_STATE_LISTEN = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_byte,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_byte,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] ctrl_byte,
  output logic       ctrl_valid,
  input  logic       ctrl_next,
  input  logic [7:0] ctrl_state,
  output logic       ctrl_abort,
  output logic       grant_active,
  output logic       grant_src,
  output logic [1:0] overflow_flags,
  output logic [1:0] timeout_flags,
  input  logic       clear_flags
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STARVE_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          grant_src_q, grant_src_d;
  logic          last_grant_q, last_grant_d;
  logic          started_q, started_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          abort_d;
  logic [1:0]    tflag_set, oflag_set;

  logic          locked, pop_any, starve_cond;
  logic [1:0]    in_valid, full, empty, push, pop;
  logic [7:0]    in_byte [2];
  logic [7:0]    head [2];

  assign in_valid   = {s1_valid, s0_valid};
  assign in_byte[0] = s0_byte;
  assign in_byte[1] = s1_byte;
  assign locked     = (state_q == LOCKED);
  assign pop_any    = locked && ctrl_next;

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;

    assign full[n]  = (wr_q[AW] != rd_q[AW]) &&
                      (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty[n] = (wr_q == rd_q);
    assign push[n]  = in_valid[n] && !full[n];
    assign pop[n]   = pop_any && !empty[n] &&
                      (grant_src_q == 1'(n));
    assign head[n]  = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push[n]) wr_q <= wr_q + PW'(1);
        if (pop[n])  rd_q <= rd_q + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[n]) mem[wr_q[AW-1:0]] <= in_byte[n];
    end
  end

  assign s0_ready     = !full[0];
  assign s1_ready     = !full[1];
  assign oflag_set    = in_valid & full;
  assign grant_active = locked;
  assign grant_src    = grant_src_q;
  assign ctrl_byte    = locked ? head[grant_src_q] : 8'h00;
  // valid drops while next is high so READY cannot re-take the same byte
  assign ctrl_valid   = locked && !empty[grant_src_q] && !ctrl_next;

  assign starve_cond = locked && empty[grant_src_q] &&
                       (ctrl_state == CONTROLLER_STATE_LISTEN);

  always_comb begin
    state_d      = state_q;
    grant_src_d  = grant_src_q;
    last_grant_d = last_grant_q;
    started_d    = started_q;
    starve_d     = starve_q;
    abort_d      = 1'b0;
    tflag_set    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (!empty[0] || !empty[1]) begin
          state_d      = LOCKED;
          grant_src_d  = empty[0] ? 1'b1 :
                         empty[1] ? 1'b0 : ~last_grant_q;
          last_grant_d = grant_src_d;
          started_d    = 1'b0;
          starve_d     = '0;
        end
      end
      LOCKED: begin
        if (ctrl_next) started_d = 1'b1;
        if (!starve_cond) starve_d = '0;
        else if (!(&starve_q)) starve_d = starve_q + CW'(1);
        if (starve_cond && starve_q == STARVE_LAST) begin
          state_d                = IDLE;
          abort_d                = 1'b1;
          tflag_set[grant_src_q] = 1'b1;
        end else if (started_q && !ctrl_next &&
                     ctrl_state == CONTROLLER_STATE_READY) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_src_q    <= 1'b0;
      last_grant_q   <= 1'b1;
      started_q      <= 1'b0;
      starve_q       <= '0;
      ctrl_abort     <= 1'b0;
      overflow_flags <= 2'b00;
      timeout_flags  <= 2'b00;
    end else begin
      state_q        <= state_d;
      grant_src_q    <= grant_src_d;
      last_grant_q   <= last_grant_d;
      started_q      <= started_d;
      starve_q       <= starve_d;
      ctrl_abort     <= abort_d;
      // a new event in the same cycle as a clear keeps its flag set
      overflow_flags <= (clear_flags ? 2'b00 : overflow_flags)
                        | oflag_set;
      timeout_flags  <= (clear_flags ? 2'b00 : timeout_flags)
                        | tflag_set;
    end
  end

endmodule

// File: doc/command_arbiter.md
# command_arbiter

- Two-source byte arbiter in front of `control_unit`. Sources are the SPI slave (source 0) and the UART receiver (source 1).
- Each source gets its own byte FIFO.
- Whole commands are granted atomically, with round-robin fairness between sources.
- Bytes are presented on the controller's `in_byte`/`in_valid`/`next` handshake.
- A stalled mid-command source is aborted after a timeout so the other host cannot be locked out.

## Interface
- `FIFO_DEPTH`, 16: per-source FIFO depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 65535: consecutive starved LISTEN cycles before abort; ≥1.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `s0_byte` / `s1_byte` in 8: source byte.
- `s0_valid` / `s1_valid` in 1: source byte strobe.
- `s0_ready` / `s1_ready` out 1: FIFO not full.
- `ctrl_byte` out 8: to controller `in_byte`.
- `ctrl_valid` out 1: to controller `in_valid`.
- `ctrl_next` in 1: controller `next` pulse.
- `ctrl_state` in 8: controller `control_state`.
- `ctrl_abort` out 1: one-cycle pulse, ORed into the controller reset.
- `grant_active` out 1: a source holds the command lock.
- `grant_src` out 1: locked source; used for `spi_output` routing.
- `overflow_flags` out 2: sticky; a write was attempted while full.
- `timeout_flags` out 2: sticky; an abort was taken against that source.
- `clear_flags` in 1: clears both flag registers.

## Operation
**FIFOs**
- Push when `sN_valid && sN_ready`.
- `sN_ready = !full`, so a push while full is refused even if a pop happens in the same cycle. A refused push sets `overflow_flags[N]`.
- Push and pop in the same cycle are legal when not full.
- Pointers are `log2(FIFO_DEPTH)+1` bits and wrap modulo 2·depth. Full = MSBs differ and the remaining bits are equal.

**Grant FSM, states IDLE / LOCKED**
- IDLE:
  - If exactly one FIFO is non-empty, lock that source.
  - If both are non-empty, lock `~last_grant`.
  - On entry to LOCKED, set `last_grant` to the locked source and clear `started` and `starve_ctr`.
- LOCKED:
  - `ctrl_byte` = head of the locked FIFO.
  - `ctrl_valid = !empty[grant_src] && !ctrl_next`.
  - When `ctrl_next` is high, pop the locked FIFO and set `started`.
  - Gating `ctrl_valid` off during `ctrl_next` keeps the controller's READY state from re-accepting the byte it just consumed.
- Release, LOCKED → IDLE, when `started && ctrl_state == CONTROLLER_STATE_READY && !ctrl_next`.
  - This covers single-byte commands (state never leaves READY) and multi-byte, swap and reset-wait commands (state returns to READY only at completion).
- Starvation:
  - In LOCKED, increment `starve_ctr` (saturating) when `ctrl_state == CONTROLLER_STATE_LISTEN && empty[grant_src]`. Clear it otherwise.
  - When `starve_ctr == TIMEOUT_CYCLES-1` and the condition still holds, pulse `ctrl_abort`, set `timeout_flags[grant_src]` and return to IDLE.
  - The FIFO is not flushed; bytes that arrive later start a new command.
- `grant_active` = (state == LOCKED).

**Simultaneous events**
- `clear_flags` and a new flag event in the same cycle: the event wins, so the flag is set.
- Arrivals on the other source while locked are only queued.

## Timing
- Reset values:
  - FIFOs empty, state IDLE, `last_grant = 1` (source 0 wins the first tie).
  - `ctrl_valid = 0`, `ctrl_byte = 0`, `ctrl_abort = 0`, `grant_active = 0`, `grant_src = 0`.
  - All flags 0, `s0_ready = s1_ready = 1`.
- Reset mid-command discards all queued bytes and the lock. The controller is reset by the same signal.
- Latency from a push into an empty FIFO with the arbiter IDLE:
  - cycle t: push;
  - t+1: non-empty, lock registered at the t+1 edge;
  - t+2: `ctrl_valid` high.
- Byte rate: the controller accepts at edge k and pulses `next` during cycle k+1. Valid is low in k+1 and the next byte is presented at k+2, giving a sustained 1 byte per 2 cycles.
- Release at the first non-`next` cycle in READY after `started`; the next grant decision is made in that IDLE cycle.
- `ctrl_abort` is exactly one cycle and is registered.

## Test plan
- Single source, 7-byte WRITE_BLOCK_INSTR pushed back-to-back on s0:
  - `ctrl_valid` rises at t+2;
  - each byte is presented once, with valid low in every `ctrl_next` cycle;
  - `grant_active` falls after the controller returns to READY;
  - `instr_out` matches the 4 payload bytes.
- Contention: s0 pushes 3-byte SET_INPUT_GAIN in the same cycle s1 pushes COMMIT_REG_UPDATES:
  - s0 is granted first and all 3 bytes complete;
  - then s1 is granted;
  - a second tie goes to s0 again only after s1 has been served (round-robin).
- Single-byte RESET_PIPELINE from s1, then s0 WRITE_BLOCK_REG:
  - release occurs 2 cycles after acceptance;
  - s1's opcode is never delivered twice.
- Starvation with `TIMEOUT_CYCLES = 8`: s0 sends opcode plus 1 of 3 needed bytes, then stops:
  - after 8 starved LISTEN cycles `ctrl_abort` pulses once and `timeout_flags = 2'b01`;
  - s1's queued command is granted next.
- Overflow with `FIFO_DEPTH = 4` and no controller progress (held in SWAP_WAIT): push 5 bytes on s0:
  - `s0_ready` falls after the 4th byte;
  - `overflow_flags[0]` sets on the 5th;
  - `clear_flags` clears it.
- Reset asserted mid-LISTEN with 2 bytes queued:
  - next cycle: FIFOs are empty, `grant_active = 0` and `ctrl_valid = 0`;
  - a new command afterwards is granted to s0 with normal t+2 latency.
